// File: rtl/bus_interconnect.sv
// Single-master address-decode interconnect: routes one CPU data request to one of
// NUM_SLAVES base/mask regions with handshake, wait states, timeout and error reporting.
module bus_interconnect #(
  parameter int unsigned                  NUM_SLAVES     = 3,
  parameter logic [NUM_SLAVES*16-1:0]     SLAVE_BASE     = {16'h2000, 16'h1000, 16'h0000},
  parameter logic [NUM_SLAVES*16-1:0]     SLAVE_MASK     = {16'hFFFF, 16'hFFFF, 16'hFFFF},
  parameter int unsigned                  TIMEOUT_CYCLES = 16,
  parameter logic [31:0]                  ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  input  logic                         m_we,
  input  logic [31:0]                  m_addr,
  input  logic [31:0]                  m_wdata,
  input  logic [3:0]                   m_wstrb,
  output logic                         m_ready,
  output logic [31:0]                  m_rdata,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_we,
  output logic [31:0]                  s_addr,
  output logic [31:0]                  s_wdata,
  output logic [3:0]                   s_wstrb,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*32-1:0]     s_rdata,
  output logic [15:0]                  err_count,
  output logic [31:0]                  last_err_addr
);

  localparam int unsigned IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]    state;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] sel_idx;
  logic [CW-1:0] cnt;
  logic          sel_ready;
  logic [31:0]   sel_rdata;
  logic          timeout;

  // Ascending scan with a found flag so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (!hit && ((m_addr[31:16] & SLAVE_MASK[16*k +: 16]) ==
                   (SLAVE_BASE[16*k +: 16] & SLAVE_MASK[16*k +: 16]))) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  assign sel_ready = s_ready[sel_idx];
  assign sel_rdata = s_rdata[32*sel_idx +: 32];
  assign timeout   = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      m_ready       <= 1'b0;
      m_rdata       <= '0;
      m_err         <= 1'b0;
      s_sel         <= '0;
      s_we          <= 1'b0;
      s_addr        <= '0;
      s_wdata       <= '0;
      s_wstrb       <= '0;
      sel_idx       <= '0;
      cnt           <= '0;
      err_count     <= '0;
      last_err_addr <= '0;
    end else begin
      m_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m_valid) begin
            if (hit) begin
              s_addr  <= m_addr;
              s_wdata <= m_wdata;
              s_wstrb <= m_wstrb;
              s_we    <= m_we;
              s_sel   <= NUM_SLAVES'(1) << hit_idx;
              sel_idx <= hit_idx;
              cnt     <= '0;
              state   <= ST_ACCESS;
            end else begin
              m_ready       <= 1'b1;
              m_rdata       <= ERR_RDATA;
              m_err         <= 1'b1;
              last_err_addr <= m_addr;
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              state         <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            m_ready <= 1'b1;
            m_rdata <= s_we ? '0 : sel_rdata;
            m_err   <= 1'b0;
            s_sel   <= '0;
            s_we    <= 1'b0;
            state   <= ST_RESP;
          end else if (timeout) begin
            m_ready       <= 1'b1;
            m_rdata       <= ERR_RDATA;
            m_err         <= 1'b1;
            s_sel         <= '0;
            s_we          <= 1'b0;
            last_err_addr <= s_addr;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect: directed scenarios plus randomized
// transactions compared against a region-table reference model.
module tb_bus_interconnect;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 16;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              m_valid;
  logic              m_we;
  logic [31:0]       m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_ready;
  logic [31:0]       m_rdata;
  logic              m_err;
  logic [NS-1:0]     s_sel;
  logic              s_we;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic [NS-1:0]     s_ready;
  logic [NS*32-1:0]  s_rdata;
  logic [15:0]       err_count;
  logic [31:0]       last_err_addr;

  // Slave 3 (0x2000-0x3FFF) overlaps slave 2 at 0x2000 so lowest-index priority is exercised.
  bus_interconnect #(
    .NUM_SLAVES    (NS),
    .SLAVE_BASE    ({16'h3000, 16'h2000, 16'h1000, 16'h0000}),
    .SLAVE_MASK    ({16'hE000, 16'hFFFF, 16'hF000, 16'hFFFF}),
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (ERRD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m_valid      (m_valid),
    .m_we         (m_we),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_ready      (m_ready),
    .m_rdata      (m_rdata),
    .m_err        (m_err),
    .s_sel        (s_sel),
    .s_we         (s_we),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_ready      (s_ready),
    .s_rdata      (s_rdata),
    .err_count    (err_count),
    .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_err_count = 0;
  logic [31:0] exp_last_err = '0;

  logic [15:0] base_tab [NS] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000};
  logic [15:0] mask_tab [NS] = '{16'hFFFF, 16'hF000, 16'hFFFF, 16'hE000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++)
      if ((a[31:16] & mask_tab[k]) == (base_tab[k] & mask_tab[k])) return k;
    return -1;
  endfunction

  function automatic logic [NS-1:0] noise(input int tgt, input bit tgt_bit);
    logic [31:0]   r;
    logic [NS-1:0] n;
    r = $urandom;
    n = r[NS-1:0];
    if (tgt >= 0) n[tgt] = tgt_bit;
    return n;
  endfunction

  // delay = wait cycles before the target slave raises ready; delay >= TO never readies.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int delay);
    int            tgt;
    int            lat;
    logic [31:0]   rd [NS];
    logic [31:0]   exp_rd;
    logic          exp_err;
    logic [NS-1:0] onehot;
    tgt = decode(addr);
    for (int k = 0; k < NS; k++) begin
      rd[k] = $urandom;
      s_rdata[32*k +: 32] = rd[k];
    end
    if (tgt < 0) begin
      lat = 1; exp_rd = ERRD; exp_err = 1'b1;
    end else if (delay >= int'(TO)) begin
      lat = TO + 1; exp_rd = ERRD; exp_err = 1'b1;
    end else begin
      lat = delay + 2; exp_rd = we ? 32'd0 : rd[tgt]; exp_err = 1'b0;
    end
    if (exp_err) begin
      if (exp_err_count < 32'hFFFF) exp_err_count++;
      exp_last_err = addr;
    end
    onehot = '0;
    if (tgt >= 0) onehot[tgt] = 1'b1;

    @(posedge clk); #1;
    m_valid = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
    s_ready = noise(tgt, 1'b0);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c < lat) begin
        check("m_ready_idle", 32'(m_ready), 32'd0);
        check("s_sel_access", 32'(s_sel), 32'(onehot));
        check("s_we_access", 32'(s_we), 32'(we));
        if (c == 1) begin
          check("s_addr", s_addr, addr);
          check("s_wdata", s_wdata, wdata);
          check("s_wstrb", 32'(s_wstrb), 32'(wstrb));
        end
        s_ready = noise(tgt, c == delay + 1);
      end else begin
        check("m_ready_resp", 32'(m_ready), 32'd1);
        check("m_rdata", m_rdata, exp_rd);
        check("m_err", 32'(m_err), 32'(exp_err));
        check("s_sel_resp", 32'(s_sel), 32'd0);
        check("err_count", 32'(err_count), exp_err_count);
        check("last_err_addr", last_err_addr, exp_last_err);
        m_valid = 1'b0;
        s_ready = '0;
      end
    end
    @(posedge clk); #1;
    check("m_ready_pulse", 32'(m_ready), 32'd0);
    check("m_rdata_hold", m_rdata, exp_rd);
    check("m_err_hold", 32'(m_err), 32'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          d;
    rst = 1'b1; m_valid = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_ready = '0; s_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_m_ready", 32'(m_ready), 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check("rst_s_sel", 32'(s_sel), 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_last_err", last_err_addr, 32'd0);
    rst = 1'b0;

    run_txn(32'h0000_0040, 1'b0, 32'h0, 4'h0, 0);
    run_txn(32'h1000_0004, 1'b1, 32'h0000_00A5, 4'b0001, 3);
    run_txn(32'h5000_0000, 1'b0, 32'h0, 4'h0, 0);
    run_txn(32'h2000_0000, 1'b0, 32'h0, 4'h0, 100);
    run_txn(32'h2000_0010, 1'b0, 32'h0, 4'h0, 1);
    run_txn(32'h3000_0000, 1'b1, 32'hCAFE_F00D, 4'b1111, 0);
    run_txn(32'h2001_0000, 1'b0, 32'h0, 4'h0, 2);
    run_txn(32'h1ABC_0020, 1'b0, 32'h0, 4'h0, 15);

    // Reset in the middle of an access to slave 1: no response must follow.
    @(posedge clk); #1;
    m_valid = 1'b1; m_we = 1'b0; m_addr = 32'h1000_0100; s_ready = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_s_sel", 32'(s_sel), 32'd0);
    check("rst_mid_m_ready", 32'(m_ready), 32'd0);
    check("rst_mid_err_count", 32'(err_count), 32'd0);
    exp_err_count = 0;
    exp_last_err = '0;
    m_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_pulse", 32'(m_ready), 32'd0);
    end
    run_txn(32'h1000_0008, 1'b0, 32'h0, 4'h0, 1);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = {16'h0000, ra[15:0]};
        1: ra = {4'h1, ra[27:0]};
        2: ra = {16'h2000, ra[15:0]};
        3: ra = {3'b001, ra[28:0]};
        default: ;
      endcase
      d = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 5));
      run_txn(ra, rb[0], $urandom, rb[7:4], d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
